// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM states
// and the byte-lane mask helper used by the top level.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = '0;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = '1;
            default: be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enable and registered read data,
// written so synthesis can map it onto block RAM.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Load/store target for the core: one request at a time, RAM access after
// LATENCY wait cycles, raw right-aligned result returned over valid/ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam bit          ZERO_LAT = (LATENCY == 0);

    state_e      r_state;
    state_e      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rsp_err;
    logic        r_rsp_load;
    logic [1:0]  r_rsp_size;
    logic [1:0]  r_rsp_off;

    logic          w_accept;
    logic          w_access;
    logic          w_we;
    logic [1:0]    w_size;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic          w_err;
    logic [3:0]    w_be;
    logic          w_ram_en;
    logic [3:0]    w_ram_be;
    logic [31:0]   w_ram_wdata;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_ram_q;
    logic [31:0]   w_shift;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // With zero latency the access happens on the acceptance edge itself, so the
    // RAM must see the live request rather than the latched copy.
    assign w_we    = ZERO_LAT ? req_we    : r_we;
    assign w_size  = ZERO_LAT ? req_size  : r_size;
    assign w_addr  = ZERO_LAT ? req_addr  : r_addr;
    assign w_wdata = ZERO_LAT ? req_wdata : r_wdata;

    assign w_err = (w_size == SZ_ILL)
                || ((w_size == SZ_HALF) && w_addr[0])
                || ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00))
                || (w_addr[31:AW+2] != '0);

    assign w_be     = byte_enable(w_size, w_addr[1:0]);
    assign w_idx    = w_addr[AW+1:2];
    assign w_ram_en = w_access && !w_err;
    assign w_ram_be = (w_ram_en && w_we) ? w_be : 4'b0000;

    always_comb begin
        w_ram_wdata = w_wdata;
        case (w_size)
            SZ_BYTE: w_ram_wdata = {4{w_wdata[7:0]}};
            SZ_HALF: w_ram_wdata = {2{w_wdata[15:0]}};
            default: w_ram_wdata = w_wdata;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_access = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next   = ZERO_LAT ? S_RESP : S_WAIT;
                    w_access = ZERO_LAT;
                end
            end
            S_WAIT: begin
                if (r_cnt == LAST) begin
                    w_next   = S_RESP;
                    w_access = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_size     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_load <= 1'b0;
            r_rsp_size <= '0;
            r_rsp_off  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 4'd1;
            end
            if (w_access) begin
                r_rsp_err  <= w_err;
                r_rsp_load <= !w_we && !w_err;
                r_rsp_size <= w_size;
                r_rsp_off  <= w_addr[1:0];
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_be    (w_ram_be),
        .i_idx   (w_idx),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    // RAM output register only changes on an access, so this stays stable in RESP.
    assign w_shift = w_ram_q >> {r_rsp_off, 3'b000};

    always_comb begin
        rsp_rdata = '0;
        if (r_rsp_load) begin
            case (r_rsp_size)
                SZ_BYTE: rsp_rdata = {24'h0, w_shift[7:0]};
                SZ_HALF: rsp_rdata = {16'h0, w_shift[15:0]};
                default: rsp_rdata = w_shift;
            endcase
        end
    end

    assign rsp_err   = r_rsp_err;
    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance driven through the
// main load/store scenarios and a LATENCY=0 instance for back-to-back traffic.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic        req_valid_0, req_ready_0, req_we_0, rsp_valid_0, rsp_ready_0, rsp_err_0;
    logic [1:0]  req_size_0;
    logic [31:0] req_addr_0, req_wdata_0, rsp_rdata_0;

    int unsigned n_checks;
    int unsigned n_fail;
    exp_t        sb[$];
    logic [7:0]  mbytes[int unsigned];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_0), .req_ready(req_ready_0), .req_we(req_we_0),
        .req_size(req_size_0), .req_addr(req_addr_0), .req_wdata(req_wdata_0),
        .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready_0),
        .rsp_rdata(rsp_rdata_0), .rsp_err(rsp_err_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference memory, independent of the RTL lane logic.
    function automatic exp_t model(input logic we, input logic [1:0] size,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int unsigned nb;
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        e.err = (size == 2'b11) || (size == 2'b01 && a[0]) ||
                (size == 2'b10 && a[1:0] != 2'b00) || (a >= DEPTH * 4);
        e.rdata = '0;
        if (!e.err) begin
            for (int unsigned i = 0; i < nb; i++) begin
                if (we) mbytes[a + i] = wd[8*i +: 8];
                else if (mbytes.exists(a + i)) e.rdata[8*i +: 8] = mbytes[a + i];
            end
        end
        return e;
    endfunction

    task automatic xact(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input int unsigned hold);
        exp_t        o;
        int unsigned n;
        sb.push_back(model(we, size, addr, wd));
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble the request bus after acceptance; the DUT must ignore it.
        req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("latency", 32'(n), 32'(LAT + 1));
        o = sb.pop_front();
        check("rdata", rsp_rdata, o.rdata);
        check("err", 32'(rsp_err), 32'(o.err));
        if (hold > 0) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
            req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        end
        for (int unsigned h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, o.rdata);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (hold > 0) begin
            @(negedge clk);
            check("post_hs_ready", 32'(req_ready), 32'd1);
            check("post_hs_valid", 32'(rsp_valid), 32'd0);
            req_valid = 1'b0;
        end
    endtask

    initial begin
        exp_t        e;
        logic [31:0] d;
        n_checks = 0; n_fail = 0;
        rst = 1'b0;
        req_valid = 0; req_we = 0; req_size = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        req_valid_0 = 0; req_we_0 = 0; req_size_0 = 0; req_addr_0 = 0; req_wdata_0 = 0;
        rsp_ready_0 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        rst = 1'b1;

        xact(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0);
        xact(1'b0, 2'b10, 32'h10, 32'h0, 0);
        xact(1'b1, 2'b00, 32'h11, 32'h000000AA, 0);
        xact(1'b0, 2'b01, 32'h10, 32'h0, 0);
        xact(1'b0, 2'b10, 32'h10, 32'h0, 0);
        xact(1'b0, 2'b00, 32'h13, 32'h0, 0);
        xact(1'b0, 2'b01, 32'h13, 32'h0, 0);
        xact(1'b0, 2'b10, 32'h12, 32'h0, 0);
        xact(1'b1, 2'b10, DEPTH * 4, 32'h12345678, 0);
        xact(1'b0, 2'b00, DEPTH * 4, 32'h0, 0);
        xact(1'b1, 2'b11, 32'h10, 32'h11111111, 0);
        xact(1'b1, 2'b01, 32'h13, 32'h0000FFFF, 0);
        xact(1'b1, 2'b01, 32'h12, 32'h00005A5A, 0);
        xact(1'b0, 2'b10, 32'h10, 32'h0, 0);
        xact(1'b1, 2'b10, DEPTH * 4 - 4, 32'h87654321, 0);
        xact(1'b0, 2'b00, DEPTH * 4 - 1, 32'h0, 0);
        xact(1'b0, 2'b10, DEPTH * 4 - 4, 32'h0, 5);

        // Reset during WAIT of a store: the store must not commit.
        xact(1'b1, 2'b10, 32'h20, 32'h11223344, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'h20; req_wdata = 32'h55667788;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rdata", rsp_rdata, 32'd0);
        check("mid_rst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 2'b10, 32'h20, 32'h0, 0);

        // Zero-latency instance: store then load every two cycles.
        for (int unsigned i = 0; i < 4; i++) begin
            d = $urandom;
            @(negedge clk);
            check("l0_ready_st", 32'(req_ready_0), 32'd1);
            req_valid_0 = 1'b1; req_we_0 = 1'b1; req_size_0 = 2'b10;
            req_addr_0 = 32'h100 + 32'(i * 8); req_wdata_0 = d;
            e.rdata = '0; e.err = 1'b0;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            check("l0_st_valid", 32'(rsp_valid_0), 32'd1);
            check("l0_st_rdata", rsp_rdata_0, e.rdata);
            check("l0_st_err", 32'(rsp_err_0), 32'(e.err));
            check("l0_busy", 32'(req_ready_0), 32'd0);
            req_we_0 = 1'b0; req_wdata_0 = ~d;
            e.rdata = d; e.err = 1'b0;
            sb.push_back(e);
            @(negedge clk);
            check("l0_gap_valid", 32'(rsp_valid_0), 32'd0);
            check("l0_ready_ld", 32'(req_ready_0), 32'd1);
            @(negedge clk);
            e = sb.pop_front();
            check("l0_ld_valid", 32'(rsp_valid_0), 32'd1);
            check("l0_ld_rdata", rsp_rdata_0, e.rdata);
            req_valid_0 = 1'b0;
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: the target end of the core's load/store port. It accepts one request at a time over a valid/ready handshake and performs a byte-, half- or word-sized read or write into a word-organised RAM after a programmable wait latency. It returns the result over a second valid/ready handshake. Load sign/zero extension stays in the core's load logic; this block returns raw data right-aligned to bit 0.

## Interface
- DEPTH_WORDS, 1024 — RAM depth in 32-bit words; power of two.
- LATENCY, 2 — wait cycles inserted between acceptance and response; 0–15.

- clk  in  1  — core clock.
- rst  in  1  — asynchronous, active-low reset.
- req_valid  in  1  — request present.
- req_ready  out  1  — block can accept a request.
- req_we  in  1  — 1 = store, 0 = load.
- req_size  in  2  — 00 byte, 01 half, 10 word, 11 illegal.
- req_addr  in  32  — byte address.
- req_wdata  in  32  — store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  — response present.
- rsp_ready  in  1  — core accepts the response.
- rsp_rdata  out  32  — load data, right-aligned, upper bits zero. 0 for stores and errors.
- rsp_err  out  1  — misaligned, out-of-range or illegal-size request.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: counts LATENCY cycles.
  - RESP: rsp_valid=1 until rsp_ready.
- Transitions:
  - IDLE→WAIT on req_valid&&req_ready, when LATENCY>0.
  - IDLE→RESP on req_valid&&req_ready, when LATENCY=0.
  - WAIT→RESP when the counter reaches LATENCY-1.
  - RESP→IDLE on rsp_ready.
- At acceptance, we/size/addr/wdata are latched. Input changes after acceptance are ignored.
- Error checks, evaluated on the latched request:
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]≠00.
  - addr ≥ DEPTH_WORDS*4.
- On error: no RAM write, rsp_rdata=0, rsp_err=1.
- Word index is addr[log2(DEPTH_WORDS)+1:2].
- Stores:
  - byte → lane addr[1:0] gets wdata[7:0].
  - half → lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - word → all four lanes.
  - Unwritten lanes are preserved.
- Loads: the selected lane(s) are shifted to bit 0, upper bits are zero, rsp_err=0.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0. RAM contents are not reset.
- Reset asserted mid-transaction: the pending transaction is dropped. A write that has not yet committed does not occur. FSM returns to IDLE.

## Timing
- Acceptance at rising edge E0. The RAM access (write commit or read capture) happens at edge E0+LATENCY. rsp_valid is high from that edge onward.
- Load latency is LATENCY+1 cycles from acceptance to the first rsp_valid cycle.
- rsp_rdata and rsp_err are registered and hold stable while rsp_valid=1 && rsp_ready=0.
- req_ready is low in WAIT and RESP. The next request can be accepted one cycle after the response handshake.
- Peak throughput is one transaction per LATENCY+2 cycles.
- A read following a write to the same word returns the updated data, since the write commits before the next acceptance.
- rsp_ready high before rsp_valid has no effect.

## Structure
- Shared package dmem_pkg holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state enum {S_IDLE, S_WAIT, S_RESP}.
  - function byte_enable(size, addr[1:0]) → 4-bit lane mask.
- Sub-module dmem_array: single-port, DEPTH_WORDS×32 RAM with a 4-bit byte-write enable and synchronous read. This keeps the RAM inferable as block RAM.
- The top level holds the FSM, latency counter, request latch, error checks, lane shifting and response registers.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 (LATENCY=2) → rsp_valid 3 cycles after acceptance, rdata=0xDEADBEEF, err=0.
- Store byte 0xAA at 0x11 over that word, then load half at 0x10 → rdata=0x0000AAEF. Load word → 0xDEADAAEF.
- Load half at 0x13, then load word at 0x12, then any access at address 4*DEPTH_WORDS → each gives err=1, rdata=0, RAM unchanged.
- Hold rsp_ready low for 5 cycles during a load → rsp_valid/rdata stable, req_ready=0, and a new req_valid is not accepted until the cycle after the handshake.
- Pull rst low during WAIT of a store to 0x20, then read 0x20 → old contents returned, outputs at reset values during reset.
- LATENCY=0 build: back-to-back store/load to the same address with rsp_ready tied high → one transaction every 2 cycles, load returns the stored value.
